prog_freq_divider: RTL and testbench
====================================

// Module: prog_freq_divider
// PURPOSE
//   Parametrised, runtime-programmable successor to the fixed toggle divider. Derives a slow
//   clock (toggle or duty-cycle mode) or a one-cycle tick (pulse mode) from the system clock.
//   Divisor, duty and mode change glitch-free through a shadow register applied only at wrap.
//   Feeds display scan, debounce and timer blocks.
// PARAMETERS
//   WIDTH        32    counter / divisor / duty width
//   DEFAULT_DIV  2500  active terminal count after reset
//   DEFAULT_DUTY 1250  active duty count after reset
//   DEFAULT_MODE 0     active mode after reset (0 toggle, 1 pulse, 2 duty)
// PORTS
//   clock        in   1      system clock, all logic on posedge
//   reset        in   1      synchronous, active-low; one clock; no other reset
//   enable       in   1      1 = count; 0 = hold count, clk_div, shadow; tick forced 0
//   sync_clear   in   1      restart period: count<=0, clk_div<=0, apply pending shadow
//   div_load     in   1      capture div_value/duty_value/mode into shadow (pending)
//   div_value    in   WIDTH  new terminal count (period = div_value+1 cycles)
//   duty_value   in   WIDTH  new high-time in cycles (duty mode only)
//   mode         in   2      00 toggle, 01 pulse, 10 duty, 11 treated as 00
//   div_ack      out  1      one-cycle pulse: shadow became active
//   clk_div      out  1      divided clock (registered)
//   tick         out  1      one-cycle strobe per period (registered, all modes)
//   count        out  WIDTH  current counter value
// BEHAVIOUR
//   - Priority per edge: reset > sync_clear > enable. All outputs registered.
//   - Reset (reset==0 at edge): count=0, clk_div=0, tick=0, div_ack=0, pending=0,
//     active div/duty/mode = DEFAULT_*.
//   - Terminal count TC = enable && count==active_div. On TC: count<=0, else count<=count+1.
//     count never exceeds active_div.
//   - tick: 1 in the cycle after TC (count==0 after wrap), else 0. div_value=0 -> tick stays 1
//     while enabled.
//   - Toggle: clk_div inverts on TC; period 2*(div+1). Pulse: clk_div held 0.
//   - Duty: clk_div <= (next_count < active_duty). duty=0 -> always 0; duty>div -> always 1.
//   - div_load: shadow <= inputs, pending<=1; a second load before apply overwrites (last wins).
//   - Apply: on TC or sync_clear with pending (or div_load in the same cycle, bypassing shadow):
//     active <= shadow, pending<=0, div_ack=1 next cycle only. New values govern next period.
//   - sync_clear: count<=0, clk_div<=0, tick<=0; applies pending/same-cycle load; ignores enable.
//   - enable low: no count, no TC, no apply; pending retained; div_ack not raised.
//   - Wrap of WIDTH arithmetic impossible since count <= active_div <= 2^WIDTH-1.
// TESTING
//   1. Reset, defaults, enable=1 -> clk_div toggles every 2501 cycles; tick pulse each wrap.
//   2. div_load div=3, mode=01 mid-period -> old period completes, div_ack 1 cycle, tick every 4.
//   3. mode=10 div=9 duty=3 -> clk_div high 3, low 7, repeat; duty=0 -> 0; duty=12 -> always 1.
//   4. enable low 5 cycles at count=7 -> count holds 7, tick 0; resumes at 8 on re-enable.
//   5. Two div_loads (div=5 then 7) before TC -> only div=7 applied, single div_ack.
//   6. reset low mid-period / sync_clear with pending -> defaults / count=0, clk_div=0, ack pulse.

Source files
------------

// File: rtl/prog_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : prog_freq_divider
// Description : Runtime-programmable frequency divider. Produces a slow clock
//               (toggle or duty-cycle mode) or a one-cycle tick (pulse mode)
//               from the system clock. New divisor/duty/mode settings are
//               staged in a shadow register and only take effect at a period
//               boundary (terminal count or sync_clear), so the output never
//               glitches mid-period.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_freq_divider #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] DEFAULT_DIV  = WIDTH'(2500),
   parameter logic [WIDTH-1:0] DEFAULT_DUTY = WIDTH'(1250),
   parameter logic [1:0]       DEFAULT_MODE = 2'd0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             sync_clear,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   input  logic [WIDTH-1:0] duty_value,
   input  logic [1:0]       mode,
   output logic             div_ack,
   output logic             clk_div,
   output logic             tick,
   output logic [WIDTH-1:0] count
);

   // Mode encodings; 2'b11 is not decoded and therefore behaves as toggle.
   localparam logic [1:0] MODE_TOGGLE = 2'd0;
   localparam logic [1:0] MODE_PULSE  = 2'd1;
   localparam logic [1:0] MODE_DUTY   = 2'd2;

   // Period state
   logic [WIDTH-1:0] count_q,   count_d;
   logic             clk_div_q, clk_div_d;
   logic             tick_q,    tick_d;
   logic             div_ack_q, div_ack_d;

   // Settings currently governing the running period
   logic [WIDTH-1:0] active_div_q,  active_div_d;
   logic [WIDTH-1:0] active_duty_q, active_duty_d;
   logic [1:0]       active_mode_q, active_mode_d;

   // Staged settings waiting for the next period boundary
   logic [WIDTH-1:0] shadow_div_q,  shadow_div_d;
   logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
   logic [1:0]       shadow_mode_q, shadow_mode_d;
   logic             pending_q,     pending_d;

   // Decoded control
   logic             tc;
   logic             load_ok;
   logic             apply;
   logic [WIDTH-1:0] src_div;
   logic [WIDTH-1:0] src_duty;
   logic [1:0]       src_mode;
   logic [WIDTH-1:0] eff_duty;
   logic [1:0]       eff_mode;
   logic [WIDTH-1:0] next_count;

   // Terminal count, apply decision and the settings that govern the next period
   always_comb begin
      tc         = enable && (count_q == active_div_q);
      // While disabled the shadow is frozen unless sync_clear consumes the load directly.
      load_ok    = div_load && (enable || sync_clear);
      apply      = (tc || sync_clear) && (pending_q || load_ok);
      // A load in the same cycle as the boundary bypasses the shadow.
      src_div    = load_ok ? div_value  : shadow_div_q;
      src_duty   = load_ok ? duty_value : shadow_duty_q;
      src_mode   = load_ok ? mode       : shadow_mode_q;
      // The register value produced at a wrap already belongs to the next period,
      // so it is computed with whichever settings govern that period.
      eff_duty   = apply ? src_duty : active_duty_q;
      eff_mode   = apply ? src_mode : active_mode_q;
      next_count = tc ? '0 : (count_q + WIDTH'(1));
   end

   // Next state of the counter and the registered outputs
   always_comb begin
      count_d   = count_q;
      clk_div_d = clk_div_q;
      tick_d    = 1'b0;
      div_ack_d = apply;
      if (sync_clear) begin
         count_d   = '0;
         clk_div_d = 1'b0;
         tick_d    = 1'b0;
      end else if (enable) begin
         count_d = next_count;
         tick_d  = tc;
         case (eff_mode)
            MODE_PULSE: clk_div_d = 1'b0;
            MODE_DUTY:  clk_div_d = (next_count < eff_duty);
            default:    clk_div_d = tc ? ~clk_div_q : clk_div_q;
         endcase
      end
   end

   // Next state of the shadow and active settings
   always_comb begin
      shadow_div_d  = shadow_div_q;
      shadow_duty_d = shadow_duty_q;
      shadow_mode_d = shadow_mode_q;
      pending_d     = pending_q;
      active_div_d  = active_div_q;
      active_duty_d = active_duty_q;
      active_mode_d = active_mode_q;
      if (load_ok) begin
         // Later loads simply overwrite earlier ones: last wins.
         shadow_div_d  = div_value;
         shadow_duty_d = duty_value;
         shadow_mode_d = mode;
         pending_d     = 1'b1;
      end
      if (apply) begin
         active_div_d  = src_div;
         active_duty_d = src_duty;
         active_mode_d = src_mode;
         pending_d     = 1'b0;
      end
   end

   // State registers with synchronous active-low reset to the default settings
   always_ff @(posedge clock) begin
      if (!reset) begin
         count_q       <= '0;
         clk_div_q     <= 1'b0;
         tick_q        <= 1'b0;
         div_ack_q     <= 1'b0;
         pending_q     <= 1'b0;
         active_div_q  <= DEFAULT_DIV;
         active_duty_q <= DEFAULT_DUTY;
         active_mode_q <= DEFAULT_MODE;
         shadow_div_q  <= DEFAULT_DIV;
         shadow_duty_q <= DEFAULT_DUTY;
         shadow_mode_q <= DEFAULT_MODE;
      end else begin
         count_q       <= count_d;
         clk_div_q     <= clk_div_d;
         tick_q        <= tick_d;
         div_ack_q     <= div_ack_d;
         pending_q     <= pending_d;
         active_div_q  <= active_div_d;
         active_duty_q <= active_duty_d;
         active_mode_q <= active_mode_d;
         shadow_div_q  <= shadow_div_d;
         shadow_duty_q <= shadow_duty_d;
         shadow_mode_q <= shadow_mode_d;
      end
   end

   assign count   = count_q;
   assign clk_div = clk_div_q;
   assign tick    = tick_q;
   assign div_ack = div_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_freq_divider
// Description : Directed self-checking bench for prog_freq_divider with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_freq_divider;

   localparam int unsigned WIDTH = 32;

   logic             clock;
   logic             reset;
   logic             enable;
   logic             sync_clear;
   logic             div_load;
   logic [WIDTH-1:0] div_value;
   logic [WIDTH-1:0] duty_value;
   logic [1:0]       mode;
   logic             div_ack;
   logic             clk_div;
   logic             tick;
   logic [WIDTH-1:0] count;

   int n_compared;
   int n_mismatched;

   prog_freq_divider #(
      .WIDTH        (WIDTH),
      .DEFAULT_DIV  (32'd2500),
      .DEFAULT_DUTY (32'd1250),
      .DEFAULT_MODE (2'd0)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .sync_clear (sync_clear),
      .div_load   (div_load),
      .div_value  (div_value),
      .duty_value (duty_value),
      .mode       (mode),
      .div_ack    (div_ack),
      .clk_div    (clk_div),
      .tick       (tick),
      .count      (count)
   );

   // 100 MHz system clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance n clock edges; outputs are sampled 1 ns after the last edge
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      reset      = 1'b0;
      enable     = 1'b0;
      sync_clear = 1'b0;
      div_load   = 1'b0;
      div_value  = '0;
      duty_value = '0;
      mode       = 2'd0;

      // ---- Reset state ----
      step(2);
      check_val("rst_count",  count,   0);
      check_val("rst_clkdiv", clk_div, 0);
      check_val("rst_tick",   tick,    0);
      check_val("rst_ack",    div_ack, 0);

      // ---- 1: defaults, toggle every 2501 cycles ----
      reset  = 1'b1;
      enable = 1'b1;
      step(2500);
      check_val("t1_count_tc",  count,   2500);
      check_val("t1_clk_pre",   clk_div, 0);
      check_val("t1_tick_pre",  tick,    0);
      step(1);
      check_val("t1_wrap_cnt",  count,   0);
      check_val("t1_wrap_tick", tick,    1);
      check_val("t1_wrap_clk",  clk_div, 1);
      step(1);
      check_val("t1_tick_off",  tick,    0);
      check_val("t1_cnt1",      count,   1);
      step(2500);
      check_val("t1_wrap2_cnt", count,   0);
      check_val("t1_wrap2_clk", clk_div, 0);
      check_val("t1_wrap2_tck", tick,    1);

      // ---- 2: load div=3 pulse mode mid-period ----
      step(10);
      div_load  = 1'b1;
      div_value = 32'd3;
      mode      = 2'd1;
      step(1);
      div_load  = 1'b0;
      check_val("t2_cnt_load",  count,   11);
      check_val("t2_ack_early", div_ack, 0);
      step(2489);
      check_val("t2_old_tc",    count,   2500);
      check_val("t2_ack_pre",   div_ack, 0);
      step(1);
      check_val("t2_apply_cnt", count,   0);
      check_val("t2_apply_tck", tick,    1);
      check_val("t2_ack",       div_ack, 1);
      step(1);
      check_val("t2_ack_off",   div_ack, 0);
      check_val("t2_cnt1",      count,   1);
      step(2);
      check_val("t2_cnt3",      count,   3);
      check_val("t2_tick3",     tick,    0);
      step(1);
      check_val("t2_wrap_cnt",  count,   0);
      check_val("t2_wrap_tick", tick,    1);
      check_val("t2_pulse_clk", clk_div, 0);

      // ---- 3: duty mode div=9 duty=3, then duty=0, then duty=12 ----
      div_load   = 1'b1;
      div_value  = 32'd9;
      duty_value = 32'd3;
      mode       = 2'd2;
      step(1);
      div_load   = 1'b0;
      step(2);
      check_val("t3_cnt3",      count,   3);
      step(1);
      check_val("t3_apply_cnt", count,   0);
      check_val("t3_ack",       div_ack, 1);
      step(9);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check_val("t3_duty_cnt", count,   i);
         check_val("t3_duty_clk", clk_div, (i < 3) ? 1 : 0);
      end
      // Load on the terminal-count cycle: applied immediately
      div_load   = 1'b1;
      duty_value = 32'd0;
      step(1);
      div_load   = 1'b0;
      check_val("t3_d0_cnt", count,   0);
      check_val("t3_d0_ack", div_ack, 1);
      check_val("t3_d0_clk", clk_div, 0);
      for (int i = 1; i < 10; i++) begin
         step(1);
         check_val("t3_d0_clk", clk_div, 0);
      end
      check_val("t3_d0_end", count, 9);
      div_load   = 1'b1;
      duty_value = 32'd12;
      step(1);
      div_load   = 1'b0;
      check_val("t3_d12_ack", div_ack, 1);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check_val("t3_d12_clk", clk_div, 1);
      end
      check_val("t3_d12_end", count, 0);

      // ---- 4: enable low holds at count 7 ----
      step(7);
      check_val("t4_cnt7", count, 7);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check_val("t4_hold_cnt",  count,   7);
         check_val("t4_hold_tick", tick,    0);
         check_val("t4_hold_clk",  clk_div, 1);
      end
      enable = 1'b1;
      step(1);
      check_val("t4_resume", count, 8);

      // ---- 5: two loads before TC, last wins ----
      step(2);
      check_val("t5_wrap", tick, 1);
      div_load  = 1'b1;
      div_value = 32'd5;
      mode      = 2'd0;
      step(1);
      div_value = 32'd7;
      step(1);
      div_load  = 1'b0;
      check_val("t5_cnt2",    count,   2);
      check_val("t5_ack_pre", div_ack, 0);
      step(7);
      check_val("t5_cnt9",    count,   9);
      check_val("t5_ack_tc",  div_ack, 0);
      step(1);
      check_val("t5_apply",   count,   0);
      check_val("t5_ack",     div_ack, 1);
      step(1);
      check_val("t5_ack_off", div_ack, 0);
      step(5);
      check_val("t5_cnt6",    count,   6);
      check_val("t5_tick6",   tick,    0);
      step(1);
      check_val("t5_cnt7",    count,   7);
      check_val("t5_ack_one", div_ack, 0);
      step(1);
      check_val("t5_wrap_c",  count,   0);
      check_val("t5_wrap_t",  tick,    1);

      // ---- 6a: reset mid-period restores defaults ----
      step(3);
      reset = 1'b0;
      step(1);
      check_val("t6_rst_cnt", count,   0);
      check_val("t6_rst_clk", clk_div, 0);
      check_val("t6_rst_tck", tick,    0);
      check_val("t6_rst_ack", div_ack, 0);
      reset = 1'b1;
      step(2500);
      check_val("t6_def_tc",  count,   2500);
      step(1);
      check_val("t6_def_wrp", count,   0);
      check_val("t6_def_tck", tick,    1);
      check_val("t6_def_clk", clk_div, 1);

      // ---- 6b: sync_clear applies a pending load ----
      step(5);
      div_load  = 1'b1;
      div_value = 32'd4;
      mode      = 2'd1;
      step(1);
      div_load  = 1'b0;
      check_val("t6_pend_cnt", count,   6);
      check_val("t6_pend_ack", div_ack, 0);
      sync_clear = 1'b1;
      step(1);
      sync_clear = 1'b0;
      check_val("t6_sc_cnt", count,   0);
      check_val("t6_sc_clk", clk_div, 0);
      check_val("t6_sc_tck", tick,    0);
      check_val("t6_sc_ack", div_ack, 1);
      step(1);
      check_val("t6_sc_ack_off", div_ack, 0);
      check_val("t6_sc_cnt1",    count,   1);
      step(3);
      check_val("t6_sc_cnt4",    count,   4);
      step(1);
      check_val("t6_sc_wrap",    count,   0);
      check_val("t6_sc_wtick",   tick,    1);

      // ---- div_value = 0: tick held high while enabled ----
      div_load   = 1'b1;
      div_value  = 32'd0;
      sync_clear = 1'b1;
      step(1);
      div_load   = 1'b0;
      sync_clear = 1'b0;
      check_val("d0_ack",  div_ack, 1);
      check_val("d0_tck0", tick,    0);
      step(1);
      check_val("d0_tick_a", tick,  1);
      check_val("d0_cnt_a",  count, 0);
      step(1);
      check_val("d0_tick_b", tick,  1);
      check_val("d0_cnt_b",  count, 0);
      enable = 1'b0;
      step(1);
      check_val("d0_dis_tick", tick, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
`default_nettype wire
